// File: rtl/peridot_pkt_pkg.sv
// peridot_pkt_pkg
// Shared constants, state types and helpers for the PERIDOT MM packetizer.
// Stream framing bytes (SOP/EOP/channel/escape), transaction codes, the
// controller state enum, the transmit sub-step enum and the packet body
// byte generator.
package peridot_pkt_pkg;

    localparam logic [7:0] SOP     = 8'h7a;
    localparam logic [7:0] EOP     = 8'h7b;
    localparam logic [7:0] CHAN    = 8'h7c;
    localparam logic [7:0] ESC     = 8'h7d;
    localparam logic [7:0] ESC_XOR = 8'h20;

    localparam logic [7:0] WR_INC  = 8'h04;
    localparam logic [7:0] RD_INC  = 8'h14;
    localparam logic [7:0] WR_RESP = 8'h84;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_RX_HUNT,
        ST_RX,
        ST_DONE
    } state_t;

    // What the byte currently presented on the output stream represents.
    typedef enum logic [1:0] {
        TS_SOP,
        TS_BODY,
        TS_ESC,
        TS_EOPM
    } tx_step_t;

    // Framing codes must never appear raw inside a packet body.
    function automatic logic needs_esc(input logic [7:0] b);
        return (b >= SOP) && (b <= ESC);
    endfunction

    // Body byte k of a single-word transaction packet (header, big-endian
    // byte address, little-endian write data).
    function automatic logic [7:0] body_byte(input logic [3:0] k, input logic wr,
                                             input logic [31:0] a, input logic [31:0] d);
        logic [7:0] b;
        case (k)
            4'd0:    b = wr ? WR_INC : RD_INC;
            4'd3:    b = 8'h04;
            4'd4:    b = a[31:24];
            4'd5:    b = a[23:16];
            4'd6:    b = a[15:8];
            4'd7:    b = a[7:0];
            4'd8:    b = d[7:0];
            4'd9:    b = d[15:8];
            4'd10:   b = d[23:16];
            4'd11:   b = d[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/peridot_pkt_unstuff.sv
// peridot_pkt_unstuff
// Removes byte stuffing and framing from the inbound response stream.
// Ports:
//   clk       clock
//   i_rst_n   synchronous active-low reset
//   i_enable  stream acceptance enable (the parent's in_ready); low clears state
//   i_valid   inbound byte valid
//   i_data    inbound byte
//   o_valid   a payload byte was accepted this cycle
//   o_data    unescaped payload byte
//   o_sop     a start-of-packet code was accepted this cycle
//   o_last    the payload byte is the final byte of the packet
module peridot_pkt_unstuff
    import peridot_pkt_pkg::*;
(
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_sop,
    output logic       o_last
);

    logic r_esc;
    logic r_eop;
    logic r_chan;
    logic w_acc;

    assign w_acc = i_enable && i_valid;

    always_comb begin
        o_valid = 1'b0;
        o_sop   = 1'b0;
        o_last  = 1'b0;
        o_data  = i_data;
        if (w_acc) begin
            if (r_chan) begin
                // channel number byte: dropped whatever its value
                o_valid = 1'b0;
            end else if (r_esc) begin
                o_valid = 1'b1;
                o_data  = i_data ^ ESC_XOR;
                o_last  = r_eop;
            end else begin
                case (i_data)
                    SOP:            o_sop = 1'b1;
                    EOP, CHAN, ESC: o_valid = 1'b0;
                    default: begin
                        o_valid = 1'b1;
                        o_last  = r_eop;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n || !i_enable) begin
            r_esc  <= 1'b0;
            r_eop  <= 1'b0;
            r_chan <= 1'b0;
        end else if (w_acc) begin
            if (r_chan) begin
                r_chan <= 1'b0;
            end else if (r_esc) begin
                r_esc <= 1'b0;
                r_eop <= 1'b0;
            end else begin
                case (i_data)
                    SOP:     r_eop  <= 1'b0;
                    EOP:     r_eop  <= 1'b1;
                    CHAN:    r_chan <= 1'b1;
                    ESC:     r_esc  <= 1'b1;
                    default: r_eop  <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: rtl/peridot_mm_packetizer.sv
// peridot_mm_packetizer
// Avalon-MM slave that turns each single-word read/write into a framed,
// byte-stuffed transaction packet and waits for the matching response packet.
// Optional response timeout: define PERIDOT_PACKETIZER_TIMEOUT_EN.
// Ports:
//   csi_clk, rsi_reset_n          clock, synchronous active-low reset
//   avs_address/read/write/...    Avalon-MM slave (waitrequest held until done)
//   out_ready/out_valid/out_data  outbound byte stream toward the PHY
//   in_ready/in_valid/in_data     inbound response byte stream
//   coe_error                     sticky protocol/timeout error
module peridot_mm_packetizer
    import peridot_pkt_pkg::*;
#(
    parameter int ADDR_WIDTH    = 30,
    parameter int TIMEOUT_CYCLE = 1000000
) (
    input  logic                  csi_clk,
    input  logic                  rsi_reset_n,
    input  logic [ADDR_WIDTH-1:0] avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [31:0]           avs_writedata,
    output logic [31:0]           avs_readdata,
    output logic                  avs_waitrequest,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    output logic                  in_ready,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  coe_error
);

    state_t      r_state;
    tx_step_t    r_step;
    logic        r_is_write;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_idx;
    logic        r_out_valid;
    logic [7:0]  r_out_data;
    logic        r_in_ready;
    logic [31:0] r_readdata;
    logic [31:0] r_rbuf;
    logic [2:0]  r_cnt;
    logic        r_resp_bad;
    logic        r_error;

    logic [31:0] w_byte_addr;
    logic [3:0]  w_last_idx;
    logic [7:0]  w_cur;
    logic [7:0]  w_nxt;
    logic [7:0]  w_pres;
    logic        w_xfer;
    logic        w_u_valid;
    logic [7:0]  w_u_byte;
    logic        w_u_sop;
    logic        w_u_last;
    logic [7:0]  w_exp;
    logic        w_bad_now;
    logic [31:0] w_rbuf_new;
    logic        w_tmo_hit;

    assign w_byte_addr = 32'({avs_address, 2'b00});
    assign w_last_idx  = r_is_write ? 4'd11 : 4'd7;
    assign w_cur       = body_byte(r_idx, r_is_write, r_addr, r_data);
    assign w_nxt       = body_byte(r_idx + 4'd1, r_is_write, r_addr, r_data);
    // After a plain body byte the next body byte follows; after SOP or the
    // EOP marker the byte at the current index is presented.
    assign w_pres      = (r_step == TS_BODY) ? w_nxt : w_cur;
    assign w_xfer      = r_out_valid && out_ready;

    assign avs_waitrequest = (r_state != ST_DONE);
    assign avs_readdata    = r_readdata;
    assign out_valid       = r_out_valid;
    assign out_data        = r_out_data;
    assign in_ready        = r_in_ready;
    assign coe_error       = r_error;

    peridot_pkt_unstuff u_unstuff (
        .clk      (csi_clk),
        .i_rst_n  (rsi_reset_n),
        .i_enable (r_in_ready),
        .i_valid  (in_valid),
        .i_data   (in_data),
        .o_valid  (w_u_valid),
        .o_data   (w_u_byte),
        .o_sop    (w_u_sop),
        .o_last   (w_u_last)
    );

    always_comb begin
        case (r_cnt)
            3'd0:    w_exp = WR_RESP;
            3'd3:    w_exp = 8'h04;
            default: w_exp = 8'h00;
        endcase
        w_rbuf_new = r_rbuf;
        case (r_cnt)
            3'd0:    w_rbuf_new[7:0]   = w_u_byte;
            3'd1:    w_rbuf_new[15:8]  = w_u_byte;
            3'd2:    w_rbuf_new[23:16] = w_u_byte;
            3'd3:    w_rbuf_new[31:24] = w_u_byte;
            default: w_rbuf_new        = r_rbuf;
        endcase
    end

    assign w_bad_now = r_resp_bad || (r_is_write && (r_cnt < 3'd4) && (w_u_byte != w_exp));

`ifdef PERIDOT_PACKETIZER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLE + 1);
    logic [TMO_W-1:0] r_tmo;

    // in_ready is high exactly while hunting for or receiving a response.
    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n || !r_in_ready || in_valid)
            r_tmo <= '0;
        else
            r_tmo <= r_tmo + 1'b1;
    end

    assign w_tmo_hit = r_in_ready && !in_valid && (r_tmo == TMO_W'(TIMEOUT_CYCLE - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLE == 0);
    assign w_tmo_hit    = 1'b0;
`endif

    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            r_state     <= ST_IDLE;
            r_step      <= TS_SOP;
            r_is_write  <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_in_ready  <= 1'b0;
            r_readdata  <= '0;
            r_rbuf      <= '0;
            r_cnt       <= '0;
            r_resp_bad  <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (avs_read || avs_write) begin
                        r_is_write  <= avs_write;
                        r_addr      <= w_byte_addr;
                        r_data      <= avs_writedata;
                        r_idx       <= '0;
                        r_step      <= TS_SOP;
                        r_out_valid <= 1'b1;
                        r_out_data  <= SOP;
                        r_state     <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (w_xfer) begin
                        if (r_step == TS_ESC) begin
                            r_out_data <= w_cur ^ ESC_XOR;
                            r_step     <= TS_BODY;
                        end else if (r_step == TS_BODY && r_idx == w_last_idx) begin
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_cnt       <= '0;
                            r_rbuf      <= '0;
                            r_resp_bad  <= 1'b0;
                            r_state     <= ST_RX_HUNT;
                        end else if (r_step == TS_BODY && r_idx + 4'd1 == w_last_idx) begin
                            r_idx      <= r_idx + 4'd1;
                            r_out_data <= EOP;
                            r_step     <= TS_EOPM;
                        end else begin
                            if (r_step == TS_BODY)
                                r_idx <= r_idx + 4'd1;
                            r_out_data <= needs_esc(w_pres) ? ESC : w_pres;
                            r_step     <= needs_esc(w_pres) ? TS_ESC : TS_BODY;
                        end
                    end
                end
                ST_RX_HUNT, ST_RX: begin
                    if (w_u_sop) begin
                        r_cnt      <= '0;
                        r_rbuf     <= '0;
                        r_resp_bad <= 1'b0;
                        r_state    <= ST_RX;
                    end else if (w_u_valid && r_state == ST_RX) begin
                        if (r_cnt < 3'd4) begin
                            r_rbuf     <= w_rbuf_new;
                            r_cnt      <= r_cnt + 3'd1;
                            r_resp_bad <= w_bad_now;
                        end else begin
                            r_error <= 1'b1;
                        end
                        if (w_u_last) begin
                            r_in_ready <= 1'b0;
                            r_state    <= ST_DONE;
                            if (!r_is_write)
                                r_readdata <= w_rbuf_new;
                            if (r_cnt != 3'd3 || w_bad_now)
                                r_error <= 1'b1;
                        end
                    end
                    if (w_tmo_hit) begin
                        r_in_ready <= 1'b0;
                        r_readdata <= 32'hFFFF_FFFF;
                        r_error    <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
